// File: rtl/fdiv_sqrt_sequencer.sv
// fdiv_sqrt_sequencer
// Queues FPU divide/sqrt requests, issues them one at a time to an iterative
// div/sqrt unit, and holds each result for writeback together with its tag.
//
// Ports
//   clock, nReset            clock and synchronous active-low reset
//   flush                    drop queued requests, squash the in-flight op
//   req_*                    request side (valid/ready, op, operands, rm, tag)
//   div_inReady/div_inValid  issue handshake toward the divider
//   div_sqrtOp/a/b/rm        operands of the FIFO head
//   div_outValid/...         one-cycle completion pulse and result
//   resp_*                   writeback side (valid/ready, result, flags, op, tag)
//
// FSM states
//   state  | meaning
//   S_IDLE | nothing in flight; may issue the FIFO head
//   S_BUSY | one op in flight; waiting for div_outValid
module fdiv_sqrt_sequencer #(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int DEPTH    = 2,
  parameter int TAGW     = 5,
  localparam int FLEN    = expWidth + sigWidth
) (
  input  logic            clock,
  input  logic            nReset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_sqrt,
  input  logic [FLEN-1:0] req_a,
  input  logic [FLEN-1:0] req_b,
  input  logic [2:0]      req_rm,
  input  logic [TAGW-1:0] req_tag,
  input  logic            div_inReady,
  output logic            div_inValid,
  output logic            div_sqrtOp,
  output logic [FLEN-1:0] div_a,
  output logic [FLEN-1:0] div_b,
  output logic [2:0]      div_rm,
  input  logic            div_outValid,
  input  logic            div_sqrtOpOut,
  input  logic [FLEN-1:0] div_out,
  input  logic [4:0]      div_flags,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [FLEN-1:0] resp_out,
  output logic [4:0]      resp_flags,
  output logic            resp_sqrt,
  output logic [TAGW-1:0] resp_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic            sqrt;
    logic [FLEN-1:0] a;
    logic [FLEN-1:0] b;
    logic [2:0]      rm;
    logic [TAGW-1:0] tag;
  } req_t;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  req_t            mem_q [DEPTH];
  req_t            head;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            full, empty, push, issue;
  state_t          state_q;
  logic            squash_q;
  logic [TAGW-1:0] inflight_tag_q;
  logic            resp_valid_q;
  logic [FLEN-1:0] resp_out_q;
  logic [4:0]      resp_flags_q;
  logic            resp_sqrt_q;
  logic [TAGW-1:0] resp_tag_q;

  // Extra pointer bit separates full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Gated by nReset so nothing is offered or issued during the reset cycle.
  assign req_ready   = nReset && !full;
  // Issue only when the result register will be free for the completion.
  assign div_inValid = nReset && (state_q == S_IDLE) && !empty && !flush &&
                       (!resp_valid_q || resp_ready);

  assign push  = req_valid && req_ready && !flush;
  assign issue = div_inValid && div_inReady;

  assign div_sqrtOp = head.sqrt;
  assign div_a      = head.a;
  assign div_b      = head.b;
  assign div_rm     = head.rm;

  assign resp_valid = resp_valid_q;
  assign resp_out   = resp_out_q;
  assign resp_flags = resp_flags_q;
  assign resp_sqrt  = resp_sqrt_q;
  assign resp_tag   = resp_tag_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{req_sqrt, req_a, req_b, req_rm, req_tag};
    end
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q        <= S_IDLE;
      squash_q       <= 1'b0;
      inflight_tag_q <= '0;
      resp_valid_q   <= 1'b0;
      resp_out_q     <= '0;
      resp_flags_q   <= '0;
      resp_sqrt_q    <= 1'b0;
      resp_tag_q     <= '0;
    end else begin
      if (flush || (resp_valid_q && resp_ready)) resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_q        <= S_BUSY;
            inflight_tag_q <= head.tag;
          end
        end
        S_BUSY: begin
          if (div_outValid) begin
            state_q  <= S_IDLE;
            squash_q <= 1'b0;
            // A flush in the completion cycle squashes this result too.
            if (!squash_q && !flush) begin
              resp_valid_q <= 1'b1;
              resp_out_q   <= div_out;
              resp_flags_q <= div_flags;
              resp_sqrt_q  <= div_sqrtOpOut;
              resp_tag_q   <= inflight_tag_q;
            end
          end else if (flush) begin
            squash_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_sqrt_sequencer.sv
module tb_fdiv_sqrt_sequencer;
  localparam int FLEN  = 32;
  localparam int TAGW  = 5;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            nReset, flush, req_valid, req_ready, req_sqrt;
  logic [FLEN-1:0] req_a, req_b;
  logic [2:0]      req_rm;
  logic [TAGW-1:0] req_tag;
  logic            div_inReady, div_inValid, div_sqrtOp;
  logic [FLEN-1:0] div_a, div_b;
  logic [2:0]      div_rm;
  logic            div_outValid, div_sqrtOpOut;
  logic [FLEN-1:0] div_out;
  logic [4:0]      div_flags;
  logic            resp_valid, resp_ready, resp_sqrt;
  logic [FLEN-1:0] resp_out;
  logic [4:0]      resp_flags;
  logic [TAGW-1:0] resp_tag;

  fdiv_sqrt_sequencer #(.expWidth(8), .sigWidth(24), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clock(clock), .nReset(nReset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_sqrt(req_sqrt),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag),
    .div_inReady(div_inReady), .div_inValid(div_inValid), .div_sqrtOp(div_sqrtOp),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm),
    .div_outValid(div_outValid), .div_sqrtOpOut(div_sqrtOpOut),
    .div_out(div_out), .div_flags(div_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
    .resp_flags(resp_flags), .resp_sqrt(resp_sqrt), .resp_tag(resp_tag)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic            sqrt;
    logic [FLEN-1:0] a, b;
    logic [2:0]      rm;
    logic [TAGW-1:0] tag;
  } mreq_t;

  mreq_t           mq[$];
  bit              m_busy, m_squash, m_rv;
  logic [TAGW-1:0] m_itag, m_rtag;
  logic [FLEN-1:0] m_rout;
  logic [4:0]      m_rflags;
  logic            m_rsqrt;

  function automatic bit exp_req_ready();
    return nReset && (mq.size() < DEPTH);
  endfunction

  function automatic bit exp_in_valid();
    return nReset && !m_busy && (mq.size() > 0) && !flush && (!m_rv || resp_ready);
  endfunction

  task automatic model_step();
    bit fire, pushing;
    if (!nReset) begin
      mq.delete();
      m_busy = 0; m_squash = 0; m_rv = 0;
      return;
    end
    fire    = exp_in_valid() && div_inReady;
    pushing = req_valid && exp_req_ready() && !flush;
    if (flush || (m_rv && resp_ready)) m_rv = 0;
    if (m_busy && div_outValid) begin
      m_busy = 0;
      if (!m_squash && !flush) begin
        m_rv = 1; m_rout = div_out; m_rflags = div_flags;
        m_rsqrt = div_sqrtOpOut; m_rtag = m_itag;
      end
      m_squash = 0;
    end else if (m_busy && flush) begin
      m_squash = 1;
    end
    if (fire) begin
      m_itag = mq[0].tag;
      void'(mq.pop_front());
      m_busy = 1;
    end
    if (flush) mq.delete();
    else if (pushing) mq.push_back('{req_sqrt, req_a, req_b, req_rm, req_tag});
  endtask

  // ---------------- divider stand-in ----------------
  bit              dv_busy, dv_pulse, dv_stall, dv_sqrt;
  int              dv_cnt, dv_lat;
  logic [FLEN-1:0] dv_a, dv_b;
  bit              dut_fire;
  logic            fire_sqrt;
  logic [FLEN-1:0] fire_a, fire_b;

  function automatic logic [FLEN-1:0] fake_result(input logic [FLEN-1:0] a, b, input logic sq);
    if (sq) return {1'b0, a[FLEN-1:1]};
    if (b == 32'h3F80_0000) return a;
    return a ^ b;
  endfunction

  function automatic logic [4:0] fake_flags(input logic [FLEN-1:0] b, input logic sq);
    if (sq) return 5'b00001;
    if (b == '0) return 5'b01000;
    return 5'b00000;
  endfunction

  // One clock: model and divider advance at the edge, inputs settle at negedge+1.
  task automatic tick();
    @(posedge clock);
    model_step();
    dv_pulse = 0;
    if (dv_busy) begin
      dv_cnt--;
      if (dv_cnt == 0) begin dv_busy = 0; dv_pulse = 1; end
    end else if (dut_fire) begin
      dv_busy = 1; dv_cnt = dv_lat;
      dv_a = fire_a; dv_b = fire_b; dv_sqrt = fire_sqrt;
    end
    @(negedge clock);
    #1;
    div_inReady   = !dv_busy && !dv_stall;
    div_outValid  = dv_pulse;
    div_sqrtOpOut = dv_pulse ? dv_sqrt : 1'b0;
    div_out       = dv_pulse ? fake_result(dv_a, dv_b, dv_sqrt) : '0;
    div_flags     = dv_pulse ? fake_flags(dv_b, dv_sqrt) : '0;
  endtask

  // ---------------- per-cycle compare ----------------
  logic [TAGW-1:0] got_tags[$];
  int              seen_rv;

  always @(negedge clock) begin
    #3;
    check("req_ready", req_ready, exp_req_ready());
    check("div_inValid", div_inValid, exp_in_valid());
    if (exp_in_valid()) begin
      check("div_a", div_a, mq[0].a);
      check("div_b", div_b, mq[0].b);
      check("div_rm", div_rm, mq[0].rm);
      check("div_sqrtOp", div_sqrtOp, mq[0].sqrt);
    end
    check("resp_valid", resp_valid, m_rv);
    if (m_rv) begin
      check("resp_out", resp_out, m_rout);
      check("resp_flags", resp_flags, m_rflags);
      check("resp_sqrt", resp_sqrt, m_rsqrt);
      check("resp_tag", resp_tag, m_rtag);
    end
    dut_fire  = div_inValid && div_inReady;
    fire_a    = div_a;
    fire_b    = div_b;
    fire_sqrt = div_sqrtOp;
    if (resp_valid) seen_rv++;
    if (resp_valid && resp_ready && nReset) got_tags.push_back(resp_tag);
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [TAGW-1:0] tag, input logic [FLEN-1:0] a, b,
                      input logic sq, input logic [2:0] rm);
    bit acc;
    int n;
    acc = 0; n = 0;
    req_tag = tag; req_a = a; req_b = b; req_sqrt = sq; req_rm = rm; req_valid = 1;
    do begin
      #1;
      acc = req_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    req_valid = 0;
    check("push_accept", acc, 1'b1);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
    check("resp_arrive", resp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 0; flush = 0; req_valid = 0; req_sqrt = 0; req_a = '0; req_b = '0;
    req_rm = '0; req_tag = '0; resp_ready = 1;
    div_inReady = 1; div_outValid = 0; div_sqrtOpOut = 0; div_out = '0; div_flags = '0;
    dv_busy = 0; dv_pulse = 0; dv_stall = 0; dv_cnt = 0; dv_lat = 3; dut_fire = 0;
    seen_rv = 0;

    // reset
    tick();
    #1;
    check("rst_req_ready_low", req_ready, 1'b0);
    check("rst_inValid", div_inValid, 1'b0);
    tick();
    nReset = 1;
    #1;
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_resp_valid", resp_valid, 1'b0);
    check("post_rst_div_a", div_a, 32'h0);
    check("post_rst_resp_out", resp_out, 32'h0);

    // single divide: 3.0 / 1.0
    push(5'd3, 32'h4040_0000, 32'h3F80_0000, 1'b0, 3'd0);
    #1;
    check("t1_issue_next_cycle", div_inValid, 1'b1);
    wait_resp();
    check("t1_resp_out", resp_out, 32'h4040_0000);
    check("t1_resp_tag", resp_tag, 5'd3);
    check("t1_resp_flags", resp_flags, 5'd0);
    repeat (2) tick();

    // back-to-back with the divider stalled: two fill the FIFO, third waits
    got_tags.delete();
    dv_stall = 1; div_inReady = 0; dv_lat = 4;
    push(5'd1, 32'h1111_0000, 32'h0000_2222, 1'b0, 3'd1);
    push(5'd2, 32'h4080_0000, 32'h0000_0000, 1'b1, 3'd2);
    #1;
    check("t2_full_req_ready", req_ready, 1'b0);
    dv_stall = 0; div_inReady = !dv_busy;
    push(5'd3, 32'hABCD_0000, 32'h0000_0000, 1'b0, 3'd4);
    for (int n = 0; n < 60 && got_tags.size() < 3; n++) tick();
    check("t2_count", got_tags.size(), 3);
    if (got_tags.size() == 3) begin
      check("t2_tag0", got_tags[0], 5'd1);
      check("t2_tag1", got_tags[1], 5'd2);
      check("t2_tag2", got_tags[2], 5'd3);
    end
    repeat (2) tick();

    // backpressure on the response side blocks the next issue
    resp_ready = 0; dv_lat = 2;
    push(5'd4, 32'h0000_0004, 32'h3F80_0000, 1'b0, 3'd0);
    push(5'd5, 32'h0000_0005, 32'h3F80_0000, 1'b0, 3'd0);
    wait_resp();
    check("t3_tag4", resp_tag, 5'd4);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("t3_blocked", div_inValid, 1'b0);
    end
    resp_ready = 1;
    #1;
    check("t3_issue_same_cycle", div_inValid, 1'b1);
    tick();
    wait_resp();
    check("t3_tag5", resp_tag, 5'd5);
    check("t3_out5", resp_out, 32'h0000_0005);
    repeat (2) tick();

    // flush while BUSY with two queued
    dv_lat = 6;
    push(5'd6, 32'h0000_0006, 32'h3F80_0000, 1'b0, 3'd0);
    push(5'd7, 32'h0000_0007, 32'h3F80_0000, 1'b0, 3'd0);
    push(5'd8, 32'h0000_0008, 32'h3F80_0000, 1'b0, 3'd0);
    seen_rv = 0;
    flush = 1;
    tick();
    flush = 0;
    #1;
    check("t4_fifo_empty_ready", req_ready, 1'b1);
    check("t4_no_issue", div_inValid, 1'b0);
    repeat (12) tick();
    check("t4_squashed", seen_rv, 0);
    dv_lat = 2;
    push(5'd9, 32'h0000_0009, 32'h3F80_0000, 1'b0, 3'd0);
    wait_resp();
    check("t4_tag9", resp_tag, 5'd9);
    repeat (2) tick();

    // flush coincident with the completion pulse
    dv_lat = 3;
    push(5'd10, 32'h0000_000A, 32'h3F80_0000, 1'b0, 3'd0);
    for (int n = 0; n < 30 && !div_outValid; n++) tick();
    check("t5_pulse_seen", div_outValid, 1'b1);
    seen_rv = 0;
    flush = 1;
    tick();
    flush = 0;
    #1;
    check("t5_dropped", resp_valid, 1'b0);
    push(5'd11, 32'h0000_000B, 32'h3F80_0000, 1'b0, 3'd0);
    wait_resp();
    check("t5_tag11", resp_tag, 5'd11);
    check("t5_out11", resp_out, 32'h0000_000B);
    repeat (2) tick();

    // reset mid-BUSY; the stale completion must be ignored
    dv_lat = 5;
    push(5'd12, 32'h0000_000C, 32'h3F80_0000, 1'b0, 3'd0);
    repeat (2) tick();
    nReset = 0;
    #1;
    check("t6_rst_req_ready", req_ready, 1'b0);
    tick();
    nReset = 1;
    #1;
    check("t6_req_ready", req_ready, 1'b1);
    check("t6_inValid", div_inValid, 1'b0);
    check("t6_resp_valid", resp_valid, 1'b0);
    check("t6_div_a", div_a, 32'h0);
    check("t6_div_b", div_b, 32'h0);
    check("t6_resp_out", resp_out, 32'h0);
    check("t6_resp_tag", resp_tag, 5'd0);
    seen_rv = 0;
    repeat (10) tick();
    check("t6_stale_ignored", seen_rv, 0);
    dv_lat = 2;
    push(5'd13, 32'h0000_000D, 32'h3F80_0000, 1'b0, 3'd0);
    wait_resp();
    check("t6_tag13", resp_tag, 5'd13);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdiv_sqrt_sequencer.md
Name: fdiv_sqrt_sequencer

Overview:
- Sits directly upstream and downstream of the iterative div/sqrt unit.
- Buffers incoming FPU div/sqrt requests in a small FIFO and issues them one at a time using the divider's inReady/inValid handshake.
- Captures the divider's single-cycle outValid result into a holding register and presents it to the FPU writeback with a valid/ready handshake and the original tag.
- Supports pipeline flush: queued requests are dropped and in-flight results are squashed.

Parameters:
- expWidth, 8, exponent width; FLEN = expWidth+sigWidth.
- sigWidth, 24, significand width including hidden bit.
- DEPTH, 2, request FIFO entries; power of 2, at least 2.
- TAGW, 5, destination tag width.

Ports:
- clock  in  1  single clock.
- nReset  in  1  synchronous, active-low reset.
- flush  in  1  drop queued requests and squash the in-flight op.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept.
- req_sqrt  in  1  1 = sqrt(a), 0 = a/b.
- req_a  in  FLEN  operand a.
- req_b  in  FLEN  operand b.
- req_rm  in  3  rounding mode.
- req_tag  in  TAGW  destination tag.
- div_inReady  in  1  divider idle.
- div_inValid  out  1  issue strobe.
- div_sqrtOp  out  1  issued op type.
- div_a  out  FLEN  issued operand a.
- div_b  out  FLEN  issued operand b.
- div_rm  out  3  issued rounding mode.
- div_outValid  in  1  one-cycle completion pulse.
- div_sqrtOpOut  in  1  completed op type.
- div_out  in  FLEN  result.
- div_flags  in  5  exception flags {NV,DZ,OF,UF,NX}.
- resp_valid  out  1  result held.
- resp_ready  in  1  consumer accepts.
- resp_out  out  FLEN  result.
- resp_flags  out  5  flags.
- resp_sqrt  out  1  op type.
- resp_tag  out  TAGW  tag of completed op.

Behaviour:
- Reset (nReset=0 at posedge): FIFO empty, state IDLE, squash=0, result register invalid. Outputs: req_ready=0 during the reset cycle, then 1; div_inValid=0; resp_valid=0; all data outputs 0.
- FIFO: push on req_valid&&req_ready; req_ready = !full (no bypass when full). Pointers are log2(DEPTH)+1 bits; full/empty come from pointer MSB compare and wrap around modulo DEPTH. There is no empty bypass: an accepted request reaches div_inValid no earlier than the next cycle.
- div_a, div_b, div_rm and div_sqrtOp are driven from the FIFO head.
- div_inValid = (state==IDLE) && !empty && !flush && (!resp_valid || resp_ready). Issue fires on div_inValid&&div_inReady. On issue: pop the head, latch its tag into inflight_tag, move to BUSY.
- Only one op is in flight. Because issue requires the result register to be free, it is always free when the completion pulse arrives.
- State machine:
  - IDLE→BUSY on issue.
  - BUSY→IDLE on div_outValid. If squash=0, load resp_out/flags/sqrt from the divider and resp_tag from inflight_tag, and set resp_valid. If squash=1, discard the result and clear squash.
  - div_outValid in IDLE is ignored.
- resp_valid clears on resp_valid&&resp_ready. Load and drain in the same cycle cannot collide, because loading requires BUSY, which required the register to be free at issue. Completion to resp_valid latency is 1 cycle.
- Flush, applied in the cycle it is asserted:
  - FIFO is emptied; a push in the same cycle is dropped.
  - No issue occurs that cycle.
  - In BUSY, squash is set; the divider is not aborted.
  - resp_valid is cleared.
  - If div_outValid coincides with flush, the result is discarded and squash is not left set.
- Flush and reset take priority over push, pop and load. Reset mid-operation returns to the reset state. Any outValid pulse that arrives after reset is ignored because the state is IDLE.
- Ordering: results are returned strictly in request order.

Test Plan:
- Single divide: push a=0x40400000, b=0x3F800000, rm=0, tag=3; divider accepts the next cycle and returns 0x40400000, flags 0 -> resp_valid=1 one cycle after outValid, resp_tag=3, resp_out=0x40400000.
- Back-to-back: push 3 requests with DEPTH=2, divider busy -> req_ready=0 after 2 accepted (third stalls until the first issue); results return with tags in order 1,2,3.
- Backpressure: hold resp_ready=0 after the first result -> div_inValid stays 0 even with the FIFO non-empty; raise resp_ready -> issue occurs in that same cycle.
- Flush while BUSY with 2 queued -> FIFO empty, resp_valid stays 0 when outValid arrives; the next request after flush returns a normal result.
- Flush coincident with div_outValid -> result dropped, squash=0 afterward; a subsequent op completes normally.
- Reset mid-BUSY (nReset=0 for 1 cycle) -> all outputs 0 and req_ready=1 next cycle; a stale outValid pulse produces no resp_valid.
